// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: fetches 32-bit commands from synchronous-read RAM and
// turns them into jump/draw strobes, shift updates and frame restarts for beam control.
module vector_list_sequencer #(
  parameter int         ADDR_W      = 10,
  parameter logic [3:0] SHIFT_RESET = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              ctrl_ready,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              jump,
  output logic              draw,
  output logic [3:0]        shift,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_HOLD       = 3'd4,
    ST_FRAME_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] OP_JUMP  = 2'b00;
  localparam logic [1:0] OP_DRAW  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic                mem_rd_r, mem_rd_s;
  logic [31:0]         cmd_r, cmd_s;
  logic [11:0]         x_r, x_s;
  logic [11:0]         y_r, y_s;
  logic                jump_r, jump_s;
  logic                draw_r, draw_s;
  logic [3:0]          shift_r, shift_s;
  logic                frame_done_r, frame_done_s;
  logic                busy_r, busy_s;
  logic                tick_pend_r, tick_pend_s;
  logic [1:0]          op_s;
  logic                last_addr_s;

  assign mem_addr   = mem_addr_r;
  assign mem_rd     = mem_rd_r;
  assign x          = x_r;
  assign y          = y_r;
  assign jump       = jump_r;
  assign draw       = draw_r;
  assign shift      = shift_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

  assign op_s        = cmd_r[31:30];
  assign last_addr_s = (mem_addr_r == ADDR_LAST);

  // Next-state and next-output decode for the fetch/issue sequence
  always_comb begin
    state_s      = state_r;
    mem_addr_s   = mem_addr_r;
    cmd_s        = cmd_r;
    x_s          = x_r;
    y_s          = y_r;
    jump_s       = 1'b0;
    draw_s       = 1'b0;
    shift_s      = shift_r;
    frame_done_s = 1'b0;

    // A tick seen outside FRAME_WAIT is remembered so END restarts immediately
    if (state_r == ST_FRAME_WAIT) begin
      tick_pend_s = tick_pend_r;
    end else begin
      tick_pend_s = tick_pend_r | frame_tick;
    end

    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        cmd_s   = mem_data;
        state_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        case (op_s)
          OP_JUMP, OP_DRAW: begin
            if (ctrl_ready) begin
              x_s    = cmd_r[23:12];
              y_s    = cmd_r[11:0];
              jump_s = (op_s == OP_JUMP);
              draw_s = (op_s == OP_DRAW);
              // Wrapping past the last word acts as an implicit END
              if (last_addr_s) begin
                mem_addr_s   = ADDR_ZERO;
                frame_done_s = 1'b1;
                state_s      = ST_FRAME_WAIT;
              end else begin
                mem_addr_s = mem_addr_r + ADDR_ONE;
                state_s    = ST_HOLD;
              end
            end else begin
              state_s = ST_ISSUE;
            end
          end
          OP_SHIFT: begin
            shift_s = cmd_r[3:0];
            if (last_addr_s) begin
              mem_addr_s   = ADDR_ZERO;
              frame_done_s = 1'b1;
              state_s      = ST_FRAME_WAIT;
            end else if (run) begin
              mem_addr_s = mem_addr_r + ADDR_ONE;
              state_s    = ST_FETCH;
            end else begin
              mem_addr_s = mem_addr_r + ADDR_ONE;
              state_s    = ST_IDLE;
            end
          end
          default: begin
            mem_addr_s   = ADDR_ZERO;
            frame_done_s = 1'b1;
            state_s      = ST_FRAME_WAIT;
          end
        endcase
      end
      ST_HOLD: begin
        // Control drops ready one cycle after the strobe, so this cycle ignores it
        if (run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FRAME_WAIT: begin
        if (tick_pend_r || frame_tick) begin
          tick_pend_s = 1'b0;
          if (run) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_FRAME_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    mem_rd_s = (state_s == ST_FETCH);
    if ((state_s == ST_IDLE) || (state_s == ST_FRAME_WAIT)) begin
      busy_s = 1'b0;
    end else begin
      busy_s = 1'b1;
    end
  end

  // State and registered outputs; reset cancels any strobe in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      mem_addr_r   <= ADDR_ZERO;
      mem_rd_r     <= 1'b0;
      cmd_r        <= 32'd0;
      x_r          <= 12'd0;
      y_r          <= 12'd0;
      jump_r       <= 1'b0;
      draw_r       <= 1'b0;
      shift_r      <= SHIFT_RESET;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      tick_pend_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      mem_addr_r   <= mem_addr_s;
      mem_rd_r     <= mem_rd_s;
      cmd_r        <= cmd_s;
      x_r          <= x_s;
      y_r          <= y_s;
      jump_r       <= jump_s;
      draw_r       <= draw_s;
      shift_r      <= shift_s;
      frame_done_r <= frame_done_s;
      busy_r       <= busy_s;
      tick_pend_r  <= tick_pend_s;
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench for vector_list_sequencer: directed display lists push expected
// strobes/frame_done events; monitors pop and compare as the DUTs emit them.
module tb_vector_list_sequencer;

  typedef struct {
    int kind;   // 0 jump, 1 draw, 2 frame_done
    int xx;
    int yy;
    int sh;
    int addr;   // mem_addr expected while the event is visible
    int gap;    // exact cycles since previous strobe, 0 = only check >= 4
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b1;
  logic        frame_tick = 1'b0;
  logic        ctrl_ready = 1'b1;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = 32'd0;
  logic [11:0] x, y;
  logic        jump, draw, frame_done, busy;
  logic [3:0]  shift;

  logic        run2 = 1'b0;
  logic        frame_tick2 = 1'b0;
  logic        ctrl_ready2 = 1'b1;
  logic [1:0]  mem_addr2;
  logic        mem_rd2;
  logic [31:0] mem_data2 = 32'd0;
  logic [11:0] x2, y2;
  logic        jump2, draw2, frame_done2, busy2;
  logic [3:0]  shift2;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem2 [0:3];

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last1 = 0, last2 = 0;
  bit   have1 = 1'b0, have2 = 1'b0;

  vector_list_sequencer #(.ADDR_W(10), .SHIFT_RESET(4'd0)) dut (
    .clk(clk), .reset(reset), .run(run), .frame_tick(frame_tick),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ctrl_ready(ctrl_ready), .x(x), .y(y), .jump(jump), .draw(draw),
    .shift(shift), .frame_done(frame_done), .busy(busy)
  );

  vector_list_sequencer #(.ADDR_W(2), .SHIFT_RESET(4'd0)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .frame_tick(frame_tick2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
    .ctrl_ready(ctrl_ready2), .x(x2), .y(y2), .jump(jump2), .draw(draw2),
    .shift(shift2), .frame_done(frame_done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM models: data one cycle after mem_rd
  always @(posedge clk) if (mem_rd) mem_data <= mem1[mem_addr];
  always @(posedge clk) if (mem_rd2) mem_data2 <= mem2[mem_addr2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input int kind, input int xx, input int yy, input int sh,
                              input int addr, input int gap);
    exp_t e;
    e.kind = kind; e.xx = xx; e.yy = yy; e.sh = sh; e.addr = addr; e.gap = gap;
    return e;
  endfunction

  function automatic logic [31:0] w_cmd(input logic [1:0] op, input logic [11:0] xx, input logic [11:0] yy);
    return {op, 6'd0, xx, yy};
  endfunction

  function automatic void check_strobe(input string tag, input exp_t e, input logic j,
                                       input logic [11:0] xx, input logic [11:0] yy,
                                       input logic [3:0] sh, input int addr,
                                       input int gap, input bit have);
    chk({tag, "_kind"}, j ? 32'd0 : 32'd1, e.kind);
    chk({tag, "_x"}, {20'd0, xx}, e.xx);
    chk({tag, "_y"}, {20'd0, yy}, e.yy);
    chk({tag, "_shift"}, {28'd0, sh}, e.sh);
    chk({tag, "_addr"}, addr, e.addr);
    if (e.gap > 0) chk({tag, "_gap"}, gap, e.gap);
    else if (have) chk({tag, "_spacing_ge4"}, {31'd0, (gap >= 4)}, 32'd1);
  endfunction

  // Monitor for the ADDR_W=10 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (jump || draw) begin
        chk("m1_exclusive", {31'd0, jump & draw}, 32'd0);
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL m1_unexpected_strobe: got jump=%0d draw=%0d x=%0d y=%0d, required no strobe", jump, draw, x, y);
        end else begin
          e1 = q1.pop_front();
          check_strobe("m1", e1, jump, x, y, shift, int'(mem_addr), cyc - last1, have1);
        end
        last1 = cyc; have1 = 1'b1;
      end
      if (frame_done) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL m1_unexpected_frame_done: got 1, required 0");
        end else begin
          e1 = q1.pop_front();
          chk("m1_fd_kind", 32'd2, e1.kind);
          chk("m1_fd_addr", {22'd0, mem_addr}, e1.addr);
        end
      end
    end
  end

  // Monitor for the ADDR_W=2 wrap instance
  always @(negedge clk) begin
    if (!reset) begin
      if (jump2 || draw2) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL m2_unexpected_strobe: got jump=%0d draw=%0d, required no strobe", jump2, draw2);
        end else begin
          e2 = q2.pop_front();
          check_strobe("m2", e2, jump2, x2, y2, shift2, int'(mem_addr2), cyc - last2, have2);
        end
        last2 = cyc; have2 = 1'b1;
      end
      if (frame_done2) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL m2_unexpected_frame_done: got 1, required 0");
        end else begin
          e2 = q2.pop_front();
          chk("m2_fd_kind", 32'd2, e2.kind);
          chk("m2_fd_addr", {30'd0, mem_addr2}, e2.addr);
        end
      end
    end
  end

  task automatic wait_cond(input int which, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      case (which)
        0: hit = draw;
        1: hit = jump;
        2: hit = frame_done;
        default: hit = frame_done2;
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: got timeout, required event within 300 cycles", name);
    end
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required completion by 100us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem1[i] = w_cmd(2'b11, 12'd0, 12'd0);
    for (int i = 0; i < 4; i++) mem2[i] = w_cmd(2'b01, 12'(i + 1), 12'(i + 1));

    // reset state
    mem1[0] = w_cmd(2'b00, 12'd100, 12'd200);
    mem1[1] = w_cmd(2'b01, 12'd3000, 12'd4000);
    mem1[2] = w_cmd(2'b11, 12'd0, 12'd0);
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_x", {20'd0, x}, 32'd0);
    chk("rst_y", {20'd0, y}, 32'd0);
    chk("rst_strobes", {30'd0, jump, draw}, 32'd0);
    chk("rst_shift", {28'd0, shift}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // test 1: JUMP, DRAW, END with ready held high
    q1.push_back(mk(1, 100, 200, 0, 1, 0));
    q1.push_back(mk(1, 3000, 4000, 0, 2, 4));
    q1[0].kind = 0;
    q1.push_back(mk(2, 0, 0, 0, 0, 0));
    @(posedge clk); #1 reset = 1'b0;
    wait_cond(2, "t1_frame_done");
    chk("t1_addr_zero", {22'd0, mem_addr}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t1_frame_wait_busy", {31'd0, busy}, 32'd0);
    chk("t1_frame_wait_addr", {22'd0, mem_addr}, 32'd0);
    chk("t1_frame_wait_rd", {31'd0, mem_rd}, 32'd0);

    // test 2: ctrl_ready low for a long ISSUE wait
    mem1[0] = w_cmd(2'b01, 12'd7, 12'd9);
    mem1[1] = w_cmd(2'b11, 12'd0, 12'd0);
    ctrl_ready = 1'b0;
    pulse_tick();
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("t2_busy_waiting", {31'd0, busy}, 32'd1);
    chk("t2_x_held", {20'd0, x}, 32'd3000);
    chk("t2_y_held", {20'd0, y}, 32'd4000);
    q1.push_back(mk(1, 7, 9, 0, 1, 0));
    q1.push_back(mk(2, 0, 0, 0, 0, 0));
    @(posedge clk); #1 ctrl_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t2_draw_next_cycle", {31'd0, draw}, 32'd1);
    @(negedge clk);
    chk("t2_draw_one_cycle", {31'd0, draw}, 32'd0);
    wait_cond(2, "t2_frame_done");

    // test 3: SHIFT(5) then DRAW(1,2)
    mem1[0] = w_cmd(2'b10, 12'd0, 12'd5);
    mem1[1] = w_cmd(2'b01, 12'd1, 12'd2);
    mem1[2] = w_cmd(2'b11, 12'd0, 12'd0);
    q1.push_back(mk(1, 1, 2, 5, 2, 0));
    q1.push_back(mk(2, 0, 0, 0, 0, 0));
    pulse_tick();
    wait_cond(2, "t3_frame_done");
    chk("t3_shift", {28'd0, shift}, 32'd5);

    // test 4: tick during the list body restarts without waiting
    mem1[0] = w_cmd(2'b00, 12'd10, 12'd20);
    mem1[1] = w_cmd(2'b01, 12'd30, 12'd40);
    mem1[2] = w_cmd(2'b11, 12'd0, 12'd0);
    for (int p = 0; p < 2; p++) begin
      q1.push_back(mk(0, 10, 20, 5, 1, 0));
      q1.push_back(mk(1, 30, 40, 5, 2, 4));
      q1.push_back(mk(2, 0, 0, 0, 0, 0));
    end
    pulse_tick();
    wait_cond(1, "t4_first_jump");
    pulse_tick();
    wait_cond(2, "t4_first_frame_done");
    @(negedge clk);
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    chk("t4_restart_rd", {31'd0, mem_rd}, 32'd1);
    chk("t4_restart_addr", {22'd0, mem_addr}, 32'd0);
    wait_cond(2, "t4_second_frame_done");
    repeat (10) @(negedge clk);
    chk("t4_no_tick_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_tick_addr", {22'd0, mem_addr}, 32'd0);

    // test 5a: run low while waiting in ISSUE, resume at the same address
    mem1[0] = w_cmd(2'b01, 12'd11, 12'd12);
    mem1[1] = w_cmd(2'b01, 12'd13, 12'd14);
    mem1[2] = w_cmd(2'b01, 12'd15, 12'd16);
    mem1[3] = w_cmd(2'b11, 12'd0, 12'd0);
    ctrl_ready = 1'b0;
    pulse_tick();
    repeat (6) @(posedge clk);
    #1;
    q1.push_back(mk(1, 11, 12, 5, 1, 0));
    run = 1'b0;
    ctrl_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_idle_addr", {22'd0, mem_addr}, 32'd1);
    chk("t5_idle_rd", {31'd0, mem_rd}, 32'd0);
    q1.push_back(mk(1, 13, 14, 5, 2, 0));
    q1.push_back(mk(1, 15, 16, 5, 3, 4));
    q1.push_back(mk(2, 0, 0, 0, 0, 0));
    @(posedge clk); #1 run = 1'b1;
    wait_cond(2, "t5_frame_done");

    // test 5b: reset while draw is high
    mem1[0] = w_cmd(2'b01, 12'd21, 12'd22);
    mem1[1] = w_cmd(2'b11, 12'd0, 12'd0);
    q1.push_back(mk(1, 21, 22, 5, 1, 0));
    pulse_tick();
    wait_cond(0, "t5_draw_before_reset");
    #1;
    reset = 1'b1;
    run = 1'b0;
    #1;
    chk("t5_rst_draw", {31'd0, draw}, 32'd0);
    chk("t5_rst_x", {20'd0, x}, 32'd0);
    chk("t5_rst_y", {20'd0, y}, 32'd0);
    chk("t5_rst_shift", {28'd0, shift}, 32'd0);
    chk("t5_rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_post_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_post_rst_draw", {31'd0, draw}, 32'd0);

    // test 6: ADDR_W=2, four DRAWs and no END -> implicit END on wrap
    q2.push_back(mk(1, 1, 1, 0, 1, 0));
    q2.push_back(mk(1, 2, 2, 0, 2, 4));
    q2.push_back(mk(1, 3, 3, 0, 3, 4));
    q2.push_back(mk(1, 4, 4, 0, 0, 4));
    q2.push_back(mk(2, 0, 0, 0, 0, 0));
    @(posedge clk); #1 run2 = 1'b1;
    wait_cond(3, "t6_wrap_frame_done");
    chk("t6_wrap_addr", {30'd0, mem_addr2}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_frame_wait_busy", {31'd0, busy2}, 32'd0);
    chk("t6_frame_wait_addr", {30'd0, mem_addr2}, 32'd0);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
